// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one request at a time to a synchronous memory.
// Optional address fault checking is enabled by defining LSU_FAULT_EN.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_*             request handshake (valid/ready) with we/addr/wdata/rd
//   rsp_*             response handshake (valid/ready) with rdata/rd/wb/fault
//   mem_*             synchronous memory port (mem_wen_n is active-low write)
//   ld_cnt, st_cnt    saturating counters of completed non-faulted accesses
module lsu_mem_ctrl #(
    parameter int          DW         = 16,
    parameter int          AW         = 8,
    parameter int unsigned ADDR_LIMIT = 'hEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [3:0]    req_rd,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [3:0]    rsp_rd,
    output logic          rsp_wb,
    output logic          rsp_fault,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen_n,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   ld_cnt,
    output logic [15:0]   st_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept_fault;

`ifdef LSU_FAULT_EN
    localparam logic [AW-1:0] LIMIT = AW'(ADDR_LIMIT);
    logic fault_q;
    assign accept_fault = (req_addr > LIMIT);
    assign rsp_fault    = fault_q;
`else
    assign accept_fault = 1'b0;
    assign rsp_fault    = 1'b0;
`endif

    // Handshake and write strobe decode straight from the state register,
    // so an asynchronous reset releases them immediately.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_wen_n = ~((state == ACCESS) && we_q);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rd    <= 4'd0;
            rsp_rdata <= '0;
            rsp_wb    <= 1'b0;
            ld_cnt    <= 16'd0;
            st_cnt    <= 16'd0;
`ifdef LSU_FAULT_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rsp_rd  <= req_rd;
`ifdef LSU_FAULT_EN
                        fault_q <= accept_fault;
`endif
                        if (accept_fault) begin
                            // Faulted requests never touch memory.
                            rsp_rdata <= '0;
                            rsp_wb    <= 1'b0;
                            state     <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        rsp_rdata <= '0;
                        rsp_wb    <= 1'b0;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_rdata <= mem_rdata;
                    rsp_wb    <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                        if (!rsp_fault) begin
                            if (we_q) begin
                                if (st_cnt != 16'hFFFF)
                                    st_cnt <= st_cnt + 16'd1;
                            end else begin
                                if (ld_cnt != 16'hFFFF)
                                    ld_cnt <= ld_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a synchronous memory model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic [3:0]  rsp_rd;
    logic        rsp_wb;
    logic        rsp_fault;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wen_n;
    logic [15:0] mem_rdata;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    logic [15:0] mem [0:255];

    int n_cmp;
    int n_bad;

    lsu_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_rd    (rsp_rd),
        .rsp_wb    (rsp_wb),
        .rsp_fault (rsp_fault),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen_n (mem_wen_n),
        .mem_rdata (mem_rdata),
        .ld_cnt    (ld_cnt),
        .st_cnt    (st_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!mem_wen_n)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [7:0] a,
                         input logic [15:0] d, input logic [3:0] rd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        req_rd    = 4'd0;
        rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wen_n", 32'(mem_wen_n), 32'd1);
        check("rst_ld_cnt", 32'(ld_cnt), 32'd0);
        check("rst_st_cnt", 32'(st_cnt), 32'd0);
        check("rst_fault", 32'(rsp_fault), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Load 0x10 -> BEEF, response two edges after accept
        issue(1'b0, 8'h10, 16'h0000, 4'd3);
        check("ld_acc_ready", 32'(req_ready), 32'd0);
        check("ld_acc_valid", 32'(rsp_valid), 32'd0);
        check("ld_acc_addr", 32'(mem_addr), 32'h10);
        check("ld_acc_wen", 32'(mem_wen_n), 32'd1);
        tick();
        check("ld_wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("ld_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ld_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
        check("ld_rsp_wb", 32'(rsp_wb), 32'd1);
        check("ld_rsp_rd", 32'(rsp_rd), 32'd3);
        check("ld_rsp_fault", 32'(rsp_fault), 32'd0);
        tick();
        check("ld_done_valid", 32'(rsp_valid), 32'd0);
        check("ld_done_ready", 32'(req_ready), 32'd1);
        check("ld_cnt_1", 32'(ld_cnt), 32'd1);

        // Store 0x1234 to 0x20: one-cycle write strobe, response one edge later
        issue(1'b1, 8'h20, 16'h1234, 4'd5);
        check("st_acc_wen", 32'(mem_wen_n), 32'd0);
        check("st_acc_wdata", 32'(mem_wdata), 32'h1234);
        check("st_acc_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("st_rsp_wen", 32'(mem_wen_n), 32'd1);
        check("st_rsp_valid", 32'(rsp_valid), 32'd1);
        check("st_rsp_wb", 32'(rsp_wb), 32'd0);
        check("st_rsp_rdata", 32'(rsp_rdata), 32'h0000);
        check("st_rsp_rd", 32'(rsp_rd), 32'd5);
        tick();
        check("st_cnt_1", 32'(st_cnt), 32'd1);
        check("st_mem", 32'(mem[8'h20]), 32'h1234);

        issue(1'b0, 8'h20, 16'h0000, 4'd7);
        tick();
        tick();
        check("ld20_valid", 32'(rsp_valid), 32'd1);
        check("ld20_rdata", 32'(rsp_rdata), 32'h1234);
        tick();
        check("ld_cnt_2", 32'(ld_cnt), 32'd2);

        // Back-pressured load; a pending request must not slip in at handshake
        rsp_ready = 1'b0;
        issue(1'b0, 8'h10, 16'h0000, 4'd9);
        tick();
        tick();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h40;
        req_wdata = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", 32'(rsp_rdata), 32'hBEEF);
            check("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("stall_done_valid", 32'(rsp_valid), 32'd0);
        check("stall_done_ready", 32'(req_ready), 32'd1);
        check("stall_done_wen", 32'(mem_wen_n), 32'd1);
        check("ld_cnt_3", 32'(ld_cnt), 32'd3);
        req_valid = 1'b0;
        tick();
        check("no_accept_mem", 32'(mem[8'h40]), 32'h0000);

        // Reset in ACCESS on a store drops it and releases the strobe at once
        issue(1'b1, 8'h30, 16'h5555, 4'd2);
        check("rst_st_wen_lo", 32'(mem_wen_n), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_wen", 32'(mem_wen_n), 32'd1);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_ld_cnt", 32'(ld_cnt), 32'd0);
        check("arst_st_cnt", 32'(st_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_nowrite", 32'(mem[8'h30]), 32'h0000);
        check("arst_idle_valid", 32'(rsp_valid), 32'd0);

        // Store above the address limit
        issue(1'b1, 8'hF5, 16'hABCD, 4'd1);
`ifdef LSU_FAULT_EN
        check("flt_valid", 32'(rsp_valid), 32'd1);
        check("flt_fault", 32'(rsp_fault), 32'd1);
        check("flt_wen", 32'(mem_wen_n), 32'd1);
        check("flt_wb", 32'(rsp_wb), 32'd0);
        check("flt_rdata", 32'(rsp_rdata), 32'h0000);
        tick();
        check("flt_st_cnt", 32'(st_cnt), 32'd0);
        check("flt_mem", 32'(mem[8'hF5]), 32'h0000);
`else
        check("hi_wen", 32'(mem_wen_n), 32'd0);
        check("hi_valid0", 32'(rsp_valid), 32'd0);
        tick();
        check("hi_valid", 32'(rsp_valid), 32'd1);
        check("hi_fault", 32'(rsp_fault), 32'd0);
        tick();
        check("hi_st_cnt", 32'(st_cnt), 32'd1);
        check("hi_mem", 32'(mem[8'hF5]), 32'hABCD);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
